// File: rtl/lu_pkg.sv
// Shared opcode encodings and widths for the pipelined logic unit.
package lu_pkg;

  localparam int unsigned LU_OP_W = 3;

  localparam logic [LU_OP_W-1:0] LU_AND   = 3'd0;
  localparam logic [LU_OP_W-1:0] LU_OR    = 3'd1;
  localparam logic [LU_OP_W-1:0] LU_NOT_A = 3'd2;
  localparam logic [LU_OP_W-1:0] LU_NOT_B = 3'd3;
  localparam logic [LU_OP_W-1:0] LU_NAND  = 3'd4;
  localparam logic [LU_OP_W-1:0] LU_NOR   = 3'd5;
  localparam logic [LU_OP_W-1:0] LU_XOR   = 3'd6;
  localparam logic [LU_OP_W-1:0] LU_XNOR  = 3'd7;

endpackage

// File: rtl/lu_core.sv
// Combinational 8-way bitwise gate function over WIDTH-bit operands.
module lu_core
  import lu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [LU_OP_W-1:0] op,
  output logic [WIDTH-1:0]   y
);

  always_comb begin
    y = '0;
    unique case (op)
      LU_AND:   y = a & b;
      LU_OR:    y = a | b;
      LU_NOT_A: y = ~a;
      LU_NOT_B: y = ~b;
      LU_NAND:  y = ~(a & b);
      LU_NOR:   y = ~(a | b);
      LU_XOR:   y = a ^ b;
      LU_XNOR:  y = ~(a ^ b);
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined logic unit; optional out_zero via LU_ZERO_FLAG_EN.
module logic_unit_pipe
  import lu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [LU_OP_W-1:0] in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic [LU_OP_W-1:0] out_op
`ifdef LU_ZERO_FLAG_EN
  ,
  output logic               out_zero
`endif
);

  logic               s1_valid_q;
  logic [WIDTH-1:0]   s1_a_q;
  logic [WIDTH-1:0]   s1_b_q;
  logic [LU_OP_W-1:0] s1_op_q;

  logic               s2_valid_q;
  logic [WIDTH-1:0]   s2_y_q;
  logic [LU_OP_W-1:0] s2_op_q;

  logic [WIDTH-1:0]   core_y;
  logic               s2_adv;

  lu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a  (s1_a_q),
    .b  (s1_b_q),
    .op (s1_op_q),
    .y  (core_y)
  );

  // in_ready is combinational from out_ready so a full pipe refills on release.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_op_q    <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_y_q  <= core_y;
          s2_op_q <= s1_op_q;
        end
      end
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_a_q  <= in_a;
          s1_b_q  <= in_b;
          s1_op_q <= in_op;
        end
      end
    end
  end

`ifdef LU_ZERO_FLAG_EN
  logic s2_zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_zero_q <= 1'b0;
    end else if (s2_adv && s1_valid_q) begin
      s2_zero_q <= (core_y == '0);
    end
  end

  assign out_zero = s2_zero_q;
`endif

  assign out_valid = s2_valid_q;
  assign out_y     = s2_y_q;
  assign out_op    = s2_op_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe at WIDTH=8 and WIDTH=1.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b, out_y;
  logic [2:0] in_op, out_op;

  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic [0:0] in_a1, in_b1, out_y1;
  logic [2:0] in_op1, out_op1;
`ifdef LU_ZERO_FLAG_EN
  logic       out_zero, out_zero1;
`endif

  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_op    (out_op)
`ifdef LU_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  logic_unit_pipe #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_a      (in_a1),
    .in_b      (in_b1),
    .in_op     (in_op1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_y     (out_y1),
    .out_op    (out_op1)
`ifdef LU_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero1)
`endif
  );

  function automatic logic [7:0] gate(input logic [7:0] a, input logic [7:0] b,
                                      input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return ~b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_valid1  = 1'b0;
    out_ready  = 1'b1;
    out_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0; out_ready1 = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_a1 = '0; in_b1 = '0; in_op1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_y !== 8'h00 || out_op !== 3'd0)
      begin errors++; $display("FAIL reset_out_data got y=%h op=%0d want 00/0", out_y, out_op); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1)
      begin errors++; $display("FAIL reset_w1 got v=%b r=%b want 0/1", out_valid1, in_ready1); end
`ifdef LU_ZERO_FLAG_EN
    checks++;
    if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got %b want 0", out_zero); end
`endif
  endtask

  task automatic test_truth_table();
    logic [7:0] exp_tt [8];
    exp_tt = '{8'hC0, 8'hFC, 8'h0F, 8'h33, 8'h3F, 8'h03, 8'h3C, 8'hC3};
    do_reset();
    for (int t = 0; t <= 10; t++) begin
      @(negedge clk);
      checks++;
      if (t >= 2 && t < 10) begin
        if (out_valid !== 1'b1 || out_y !== exp_tt[t-2] || out_op !== 3'(t-2))
          begin errors++; $display("FAIL truth_op%0d got v=%b y=%h op=%0d want 1/%h/%0d",
                                   t-2, out_valid, out_y, out_op, exp_tt[t-2], t-2); end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL truth_idle t=%0d got v=%b want 0", t, out_valid);
      end
      if (t < 8) begin
        in_valid = 1'b1; in_a = 8'hF0; in_b = 8'hCC; in_op = 3'(t);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (t < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL truth_ready t=%0d got %b want 1", t, in_ready); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] a[3], b[3], r[3];
    logic [2:0] o[3];
    for (int i = 0; i < 3; i++) begin
      a[i] = 8'($urandom); b[i] = 8'($urandom); o[i] = 3'($urandom); r[i] = gate(a[i], b[i], o[i]);
    end
    do_reset();
    out_ready = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (t < 3) begin in_valid = 1'b1; in_a = a[t]; in_b = b[t]; in_op = o[t]; end
      else if (t >= 5) in_valid = 1'b0;
      if (t == 4) out_ready = 1'b1;
      #1;
      if (t <= 1 || t == 4) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready t=%0d got %b want 1", t, in_ready); end
      end else if (t == 2 || t == 3) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_refuse t=%0d got %b want 0", t, in_ready); end
      end
      if (t >= 2 && t <= 6) begin
        int k;
        k = (t <= 4) ? 0 : t - 4;
        checks++;
        if (out_valid !== 1'b1 || out_y !== r[k] || out_op !== o[k])
          begin errors++; $display("FAIL bp_out t=%0d got v=%b y=%h op=%0d want 1/%h/%0d",
                                   t, out_valid, out_y, out_op, r[k], o[k]); end
      end
      if (t == 7) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got v=%b want 0", out_valid); end
      end
    end
  endtask

  task automatic test_width1();
    logic [3:0] tt [8];
    int k;
    // Bit {a,b} of each entry is the gate output for those inputs.
    tt = '{4'b1000, 4'b1110, 4'b0011, 4'b0101, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
    do_reset();
    for (int t = 0; t <= 34; t++) begin
      @(negedge clk);
      k = t - 2;
      checks++;
      if (t >= 2 && t < 34) begin
        if (out_valid1 !== 1'b1 || out_y1 !== tt[k/4][k%4] || out_op1 !== 3'(k/4))
          begin errors++; $display("FAIL w1_op%0d_ab%0d got v=%b y=%b op=%0d want 1/%b/%0d",
                                   k/4, k%4, out_valid1, out_y1, out_op1, tt[k/4][k%4], k/4); end
      end else if (out_valid1 !== 1'b0) begin
        errors++; $display("FAIL w1_idle t=%0d got v=%b want 0", t, out_valid1);
      end
      if (t < 32) begin
        in_valid1 = 1'b1; in_op1 = 3'(t/4); in_a1 = 1'((t % 4) >> 1); in_b1 = 1'(t % 2);
      end else begin
        in_valid1 = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (t < 2) begin
        in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom);
      end else if (t == 2) begin
        rst = 1'b1; in_valid = 1'b1; in_a = 8'h5A; in_b = 8'hA5; in_op = 3'd6;
      end else begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid t=%0d got %b want 0", t, out_valid); end
        if (t == 3) begin
          checks++;
          if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
        end
      end
    end
  endtask

  task automatic test_random_stall();
    int n = 1000;
    int sent = 0, recvd = 0, cyc = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_y = '0;
    logic [2:0] prev_op = '0;
    logic exp_ready;
    logic [10:0] e;
    do_reset();
    exp_q.delete();
    while ((sent < n || recvd < n) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 9) < 6);
      if (sent < n && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_y !== prev_y || out_op !== prev_op)
          begin errors++; $display("FAIL rnd_stable cyc=%0d got v=%b y=%h op=%0d want 1/%h/%0d",
                                   cyc, out_valid, out_y, out_op, prev_y, prev_op); end
      end
      exp_ready = (exp_q.size() < 2) || out_ready;
      checks++;
      if (in_ready !== exp_ready)
        begin errors++; $display("FAIL rnd_ready cyc=%0d got %b want %b", cyc, in_ready, exp_ready); end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra cyc=%0d got y=%h want no result", cyc, out_y);
        end else begin
          e = exp_q.pop_front();
          recvd++;
          if ({out_op, out_y} !== e)
            begin errors++; $display("FAIL rnd_data #%0d got op=%0d y=%h want op=%0d y=%h",
                                     recvd, out_op, out_y, e[10:8], e[7:0]); end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back({in_op, gate(in_a, in_b, in_op)});
        sent++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_y = out_y;
      prev_op = out_op;
    end
    in_valid = 1'b0;
    checks++;
    if (sent != n || recvd != n)
      begin errors++; $display("FAIL rnd_count got sent=%0d recvd=%0d want %0d each", sent, recvd, n); end
  endtask

`ifdef LU_ZERO_FLAG_EN
  task automatic test_zero_flag();
    do_reset();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (t == 2) begin
        checks++;
        if (out_y !== 8'h00 || out_zero !== 1'b1 || out_valid !== 1'b1)
          begin errors++; $display("FAIL zero_and got y=%h z=%b want 00/1", out_y, out_zero); end
      end else if (t == 3) begin
        checks++;
        if (out_y !== 8'hFF || out_zero !== 1'b0 || out_valid !== 1'b1)
          begin errors++; $display("FAIL zero_or got y=%h z=%b want FF/0", out_y, out_zero); end
      end
      in_valid = (t < 2);
      in_a = 8'hAA; in_b = 8'h55; in_op = (t == 0) ? 3'd0 : 3'd1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_truth_table();
    test_backpressure();
    test_width1();
    test_reset_mid();
    test_random_stall();
`ifdef LU_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-bit basic gates block.
- Applies one of eight bitwise gate functions to WIDTH-bit operands A and B, selected per transaction by an opcode.
- Two register stages with valid/ready handshakes on both sides; full throughput of one result per cycle; stalls cleanly under backpressure.
- Sits between an operand source and a result consumer in the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block accepts a transaction this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  opcode (see Behaviour).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- out_y  output  WIDTH  result.
- out_op  output  3  opcode that produced out_y.
- out_zero  output  1  out_y == 0 (only with LU_ZERO_FLAG_EN).

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Opcodes:
  - 0 AND = A&B
  - 1 OR = A|B
  - 2 NOT_A = ~A
  - 3 NOT_B = ~B
  - 4 NAND = ~(A&B)
  - 5 NOR = ~(A|B)
  - 6 XOR = A^B
  - 7 XNOR = ~(A^B)
  - All operations are bitwise across WIDTH.
- Reset values:
  - s1_valid = 0, s2_valid = 0, out_valid = 0.
  - out_y = 0, out_op = 0, out_zero = 0.
  - in_ready = 1 in the first cycle after reset.
- Stage 1 register (a, b, op, s1_valid):
  - Loads when in_valid && in_ready.
- Stage 2 register (y, op, s2_valid):
  - Loads the result of the gate function applied to stage 1 contents when stage 1 advances.
  - out_y, out_op and out_valid are driven directly from stage 2 registers.
- Advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = s1_valid && s2_adv
  - in_ready = !s1_valid || s2_adv (combinational from out_ready).
- Stage transitions:
  - Stage 2: if s2_adv, s2_valid <= s1_valid and data is loaded when s1_valid; otherwise hold.
  - Stage 1: if in_ready, s1_valid <= in_valid and data is loaded when in_valid; otherwise hold.
- Latency: accepted transaction appears on out_* exactly 2 cycles after acceptance when unstalled.
- Throughput: 1 transaction per cycle with out_ready held high.
- Backpressure:
  - While out_valid && !out_ready, out_y and out_op are stable.
  - Up to 2 transactions are held; a third is refused (in_ready = 0).
- Release: in the cycle out_ready rises with both stages full, in_ready = 1 and a new transaction is accepted simultaneously. No bubble, no loss, no duplication.
- Empty pipeline: out_valid = 0. out_y holds its last value and must not be interpreted.
- in_op values are all defined; no illegal opcode exists.
- Reset mid-operation: all in-flight transactions are discarded and valids clear at the next edge regardless of handshakes. A transaction offered in the reset cycle is not accepted.

Optional Feature:
- Macro: LU_ZERO_FLAG_EN.
- Defined:
  - Port out_zero exists.
  - Registered in stage 2 alongside out_y as (result == 0).
  - Obeys the same stall and reset rules as out_y.
- Undefined: port out_zero and its register are absent; all other behaviour is identical.

Decomposition:
- Package lu_pkg holds:
  - opcode localparams LU_AND..LU_XNOR (3-bit)
  - LU_OP_W = 3
- Sub-module lu_core: purely combinational, parameter WIDTH. Inputs a, b, op; output y. Implements the 8-way gate function.
- logic_unit_pipe instantiates lu_core once, between stage 1 and stage 2.

Test Plan:
- Truth-table sweep:
  - Stimulus: WIDTH=8, A=8'hF0, B=8'hCC, ops 0..7 back-to-back, out_ready=1.
  - Required: out_y = C0, FC, 0F, 33, 3F, 03, 3C, C3, each 2 cycles after acceptance, one per cycle.
- Backpressure:
  - Stimulus: out_ready=0 while offering 3 transactions.
  - Required: first two accepted, in_ready=0 on the third, out_y frozen on the first result. Raising out_ready drains in order and the third is accepted the same cycle.
- Width scaling:
  - Stimulus: WIDTH=1, all 4 (A,B) combinations × 8 ops.
  - Required: results match the single-bit gate truth table exactly.
- Reset mid-stream:
  - Stimulus: 2 transactions in flight, assert rst for 1 cycle.
  - Required: out_valid=0 and in_ready=1 the cycle after; no stale result ever appears.
- Random stall:
  - Stimulus: 1000 random operands/opcodes with random in_valid/out_ready.
  - Required: a scoreboard sees every result in order, none lost or duplicated, and out_* stable during stalls.
- Zero flag (LU_ZERO_FLAG_EN defined):
  - Stimulus: A=8'hAA, B=8'h55, op AND.
  - Required: out_y=00, out_zero=1. With op OR: out_y=FF, out_zero=0.
